// File: rtl/mem_arbiter_if.sv
// Single-word memory request/response channel shared by both cache
// ports and the downstream memory side of the arbiter.
interface mem_arbiter_if;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;

    modport master (
        output ren, wen, addr, mask, wdata,
        input  ready, valid, rdata
    );

    modport slave (
        input  ren, wen, addr, mask, wdata,
        output ready, valid, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port I/D cache arbiter onto one pipelined memory, owner-FIFO routed.
// Define MEM_ARB_RR_EN for round-robin; otherwise port 1 wins conflicts.
module mem_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mem_arbiter_if.slave  i_p0,
    mem_arbiter_if.slave  i_p1,
    mem_arbiter_if.master o_mem,
    output logic          o_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic          w_req0;
    logic          w_req1;
    logic          w_g0;
    logic          w_g1;
    logic          w_ren;
    logic          w_wen;
    logic [31:0]   w_addr;
    logic [3:0]    w_mask;
    logic [31:0]   w_wdata;
    logic          w_space;
    logic          w_ok;
    logic          w_push;
    logic          w_pop;
    logic          w_head;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic [DEPTH-1:0] r_owner;
    logic          r_err;

    assign w_req0 = i_p0.ren | i_p0.wen;
    assign w_req1 = i_p1.ren | i_p1.wen;

`ifdef MEM_ARB_RR_EN
    logic r_prio;
    logic w_xfer;

    assign w_g0 = w_req0 & (~w_req1 | ~r_prio);
    assign w_g1 = w_req1 & (~w_req0 | r_prio);
    assign w_xfer = (o_mem.ren | o_mem.wen) & o_mem.ready;

    // Loser of the last accepted transfer gets the next conflict.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio <= 1'b0;
        end else if (w_xfer) begin
            r_prio <= ~w_g1;
        end
    end
`else
    assign w_g1 = w_req1;
    assign w_g0 = w_req0 & ~w_req1;
`endif

    always_comb begin
        w_ren   = 1'b0;
        w_wen   = 1'b0;
        w_addr  = '0;
        w_mask  = '0;
        w_wdata = '0;
        unique case (1'b1)
            w_g0: begin
                w_ren   = i_p0.ren;
                w_wen   = i_p0.wen & ~i_p0.ren;
                w_addr  = i_p0.addr;
                w_mask  = i_p0.mask;
                w_wdata = i_p0.wdata;
            end
            w_g1: begin
                w_ren   = i_p1.ren;
                w_wen   = i_p1.wen & ~i_p1.ren;
                w_addr  = i_p1.addr;
                w_mask  = i_p1.mask;
                w_wdata = i_p1.wdata;
            end
            default: ;
        endcase
    end

    // A full FIFO still takes a read when the head is popping this cycle.
    assign w_space = (r_count < FULL)
                   | ((r_count == FULL) & o_mem.valid);
    assign w_ok    = ~w_ren | w_space;

    assign o_mem.ren   = i_rst_n & w_ren & w_space;
    assign o_mem.wen   = i_rst_n & w_wen;
    assign o_mem.addr  = w_addr;
    assign o_mem.mask  = w_mask;
    assign o_mem.wdata = w_wdata;

    assign i_p0.ready = i_rst_n & w_g0 & o_mem.ready & w_ok;
    assign i_p1.ready = i_rst_n & w_g1 & o_mem.ready & w_ok;

    assign w_push = o_mem.ren & o_mem.ready;
    assign w_pop  = i_rst_n & o_mem.valid & (r_count != '0);
    assign w_head = r_owner[r_rd];

    assign i_p0.valid = w_pop & ~w_head;
    assign i_p1.valid = w_pop & w_head;
    assign i_p0.rdata = o_mem.rdata;
    assign i_p1.rdata = o_mem.rdata;
    assign o_err      = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_owner <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_owner[r_wr] <= w_g1;
                r_wr          <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (o_mem.valid && r_count == '0) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: pipelined memory model plus per-port scoreboards.
// Responses are checked for data, owner and exact memory latency.
module tb_mem_arbiter;
    typedef struct {
        logic [31:0] d;
        int          due;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic err;
    logic mem_rdy = 1'b1;
    int   lat = 4;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   nresp0 = 0;
    int   nresp1 = 0;
    ent_t pipe[$];
    ent_t sb0[$];
    ent_t sb1[$];
    logic [31:0] wmem [logic [31:0]];

    mem_arbiter_if p0();
    mem_arbiter_if p1();
    mem_arbiter_if mif();

    mem_arbiter #(.DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_p0    (p0),
        .i_p1    (p1),
        .o_mem   (mif),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    assign mif.ready = mem_rdy;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return (a ^ 32'h5A5A_0000) + 32'h0000_1000;
    endfunction

    // Memory model: fixed latency, in-order, one request per cycle.
    always begin
        logic        c_ren;
        logic        c_wen;
        logic        c_a0;
        logic        c_a1;
        logic [31:0] c_addr;
        logic [31:0] c_wd;
        logic [31:0] c_p0a;
        logic [31:0] c_p1a;
        logic [31:0] o;
        logic [3:0]  c_m;
        @(negedge clk);
        c_ren  = mif.ren & mif.ready;
        c_wen  = mif.wen & mif.ready;
        c_addr = mif.addr;
        c_wd   = mif.wdata;
        c_m    = mif.mask;
        c_a0   = p0.ready & p0.ren;
        c_a1   = p1.ready & p1.ren;
        c_p0a  = p0.addr;
        c_p1a  = p1.addr;
        @(posedge clk);
        if (mif.valid && pipe.size() > 0) void'(pipe.pop_front());
        if (c_ren) pipe.push_back('{rd(c_addr), cyc + lat});
        if (c_a0) sb0.push_back('{rd(c_p0a), cyc + lat});
        if (c_a1) sb1.push_back('{rd(c_p1a), cyc + lat});
        if (c_wen) begin
            o = rd(c_addr);
            for (int b = 0; b < 4; b++)
                if (c_m[b]) o[8*b +: 8] = c_wd[8*b +: 8];
            wmem[c_addr] = o;
        end
        cyc++;
        #1;
        mif.valid = (pipe.size() > 0) && (pipe[0].due == cyc);
        mif.rdata = mif.valid ? pipe[0].d : 32'h0;
    end

    // Response monitor: pop the port's scoreboard on each valid.
    always @(negedge clk) begin
        ent_t e;
        if (p0.valid) begin
            nresp0++;
            checks++;
            if (sb0.size() == 0) begin
                errors++;
                $display("FAIL p0_unexpected: got valid rdata=%h, required none",
                         p0.rdata);
            end else begin
                e = sb0.pop_front();
                if (p0.rdata !== e.d || cyc != e.due) begin
                    errors++;
                    $display("FAIL p0_resp: got %h @%0d, required %h @%0d",
                             p0.rdata, cyc, e.d, e.due);
                end
            end
        end
        if (p1.valid) begin
            nresp1++;
            checks++;
            if (sb1.size() == 0) begin
                errors++;
                $display("FAIL p1_unexpected: got valid rdata=%h, required none",
                         p1.rdata);
            end else begin
                e = sb1.pop_front();
                if (p1.rdata !== e.d || cyc != e.due) begin
                    errors++;
                    $display("FAIL p1_resp: got %h @%0d, required %h @%0d",
                             p1.rdata, cyc, e.d, e.due);
                end
            end
        end
    end

    task automatic idle();
        p0.ren = 0; p0.wen = 0; p0.addr = '0; p0.mask = '0; p0.wdata = '0;
        p1.ren = 0; p1.wen = 0; p1.addr = '0; p1.mask = '0; p1.wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        sb0.delete();
        sb1.delete();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (sb0.size() == 0 && sb1.size() == 0 && pipe.size() == 0
                && !mif.valid) ok = 1;
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic send(input bit port, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int acc,
                        output logic [31:0] maddr, output bit ok);
        ok = 0; acc = -1; maddr = '0;
        if (port) begin
            p1.ren = !wr; p1.wen = wr; p1.addr = a; p1.wdata = d; p1.mask = m;
        end else begin
            p0.ren = !wr; p0.wen = wr; p0.addr = a; p0.wdata = d; p0.mask = m;
        end
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (port ? p1.ready : p0.ready) begin
                ok = 1; acc = cyc; maddr = mif.addr;
            end
            @(posedge clk); #1;
        end
        idle();
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        idle();
        mif.valid = 0;
        mif.rdata = '0;
        #1 rst_n = 0;
        p0.ren = 1; p1.wen = 1;
        #1;
        outs = {p0.ready, p1.ready, p0.valid, p1.valid, mif.ren, mif.wen};
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 000000", outs);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b, required 0", err);
        end
        idle();
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({mif.ren, mif.wen, mif.addr, mif.mask, mif.wdata} !== 70'b0) begin
            errors++;
            $display("FAIL idle_bus: got addr=%h mask=%h wdata=%h, required 0",
                     mif.addr, mif.mask, mif.wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        int acc;
        logic [31:0] ma;
        bit ok;
        lat = 4; nresp0 = 0; nresp1 = 0;
        send(0, 0, 32'h10, 32'h0, 4'hF, acc, ma, ok);
        checks++;
        if (!ok || ma !== 32'h10) begin
            errors++;
            $display("FAIL single_accept: got ok=%0d addr=%h, required 1 00000010",
                     ok, ma);
        end
        wait_idle(ok);
        checks++;
        if (!ok || nresp0 != 1 || nresp1 != 0) begin
            errors++;
            $display("FAIL single_resp: got p0=%0d p1=%0d, required 1 0",
                     nresp0, nresp1);
        end
    endtask

    task automatic test_conflict();
        int g[$];
        int n0, n1, exp_g, got_g;
        bit a0, a1, ok;
        do_reset();
        lat = 4; nresp0 = 0; nresp1 = 0; n0 = 0; n1 = 0;
        for (int t = 0; t < 100 && (n0 < 4 || n1 < 4); t++) begin
            p0.ren = (n0 < 4); p0.addr = 32'h100 + 32'(n0); p0.mask = 4'hF;
            p1.ren = (n1 < 4); p1.addr = 32'h200 + 32'(n1); p1.mask = 4'hF;
            @(negedge clk);
            a0 = p0.ready; a1 = p1.ready;
            @(posedge clk); #1;
            if (a0) begin g.push_back(0); n0++; end
            if (a1) begin g.push_back(1); n1++; end
        end
        idle();
        for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_g = i % 2;
`else
            exp_g = (i < 4) ? 1 : 0;
`endif
            got_g = (i < g.size()) ? g[i] : -1;
            checks++;
            if (got_g != exp_g) begin
                errors++;
                $display("FAIL conflict_grant%0d: got %0d, required %0d",
                         i, got_g, exp_g);
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok || nresp0 != 4 || nresp1 != 4) begin
            errors++;
            $display("FAIL conflict_resp: got p0=%0d p1=%0d, required 4 4",
                     nresp0, nresp1);
        end
    endtask

    task automatic test_full_fifo();
        int n0, first, fifth, stall;
        bit wrdone, w1rdy, v5, ok;
        do_reset();
        lat = 8; nresp0 = 0; nresp1 = 0;
        n0 = 0; first = -1; fifth = -1; stall = 0;
        wrdone = 0; w1rdy = 0; v5 = 0;
        for (int t = 0; t < 100 && n0 < 5; t++) begin
            p0.ren = 1; p0.addr = 32'h300 + 32'(n0); p0.mask = 4'hF;
            p1.wen = (stall > 0 && !wrdone);
            p1.addr = 32'h40; p1.wdata = 32'h1234_5678; p1.mask = 4'hF;
            @(negedge clk);
            if (p1.wen) begin w1rdy = p1.ready; wrdone = 1; end
            if (p0.ready) begin
                if (n0 == 0) first = cyc;
                if (n0 == 4) begin fifth = cyc; v5 = mif.valid; end
                n0++;
            end else if (n0 == 4 && !p1.wen) begin
                stall++;
            end
            @(posedge clk); #1;
        end
        idle();
        checks++;
        if (fifth != first + 8 || v5 !== 1'b1) begin
            errors++;
            $display("FAIL full_fifth: got edge %0d valid=%b, required %0d 1",
                     fifth, v5, first + 8);
        end
        checks++;
        if (stall != 3) begin
            errors++;
            $display("FAIL full_stall: got %0d, required 3", stall);
        end
        checks++;
        if (w1rdy !== 1'b1) begin
            errors++;
            $display("FAIL full_write: got ready=%b, required 1", w1rdy);
        end
        wait_idle(ok);
        checks++;
        if (!ok || nresp0 != 5 || nresp1 != 0) begin
            errors++;
            $display("FAIL full_resp: got p0=%0d p1=%0d, required 5 0",
                     nresp0, nresp1);
        end
    endtask

    task automatic test_mixed();
        int acc;
        logic [31:0] ma, got;
        bit ok, seen;
        lat = 4; nresp0 = 0; nresp1 = 0;
        send(1, 1, 32'h20, 32'hDEAD_BEEF, 4'hF, acc, ma, ok);
        send(0, 0, 32'h20, 32'h0, 4'hF, acc, ma, ok);
        seen = 0; got = '0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (p0.valid) begin seen = 1; got = p0.rdata; end
        end
        @(posedge clk); #1;
        checks++;
        if (!seen || got !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mixed_data: got %h seen=%0d, required deadbeef",
                     got, seen);
        end
        wait_idle(ok);
        checks++;
        if (!ok || nresp0 != 1 || nresp1 != 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mixed_route: got p0=%0d p1=%0d err=%b, required 1 0 0",
                     nresp0, nresp1, err);
        end
    endtask

    task automatic test_reset_midflight();
        int n;
        bit a, ok;
        logic [5:0] outs;
        lat = 4; nresp0 = 0; nresp1 = 0; n = 0;
        p0.ren = 1; p0.addr = 32'h50; p0.mask = 4'hF;
        for (int t = 0; t < 20 && n < 2; t++) begin
            @(negedge clk);
            a = p0.ready;
            @(posedge clk); #1;
            if (a) begin n++; p0.addr = 32'h51; end
        end
        p0.ren = 0;
        @(posedge clk); #1;
        rst_n = 0;
        p0.ren = 1; p1.ren = 1;
        #1;
        outs = {p0.ready, p1.ready, p0.valid, p1.valid, mif.ren, mif.wen};
        checks++;
        if (n != 2 || outs !== 6'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b n=%0d, required 000000 2",
                     outs, n);
        end
        sb0.delete();
        sb1.delete();
        @(posedge clk); #1;
        idle();
        rst_n = 1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_err_clear: got %b, required 0", err);
        end
        wait_idle(ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!ok || err !== 1'b1 || nresp0 != 0 || nresp1 != 0) begin
            errors++;
            $display("FAIL stale_valid: got err=%b p0=%0d p1=%0d, required 1 0 0",
                     err, nresp0, nresp1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_conflict();
        test_full_fifo();
        test_mixed();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
